// File: rtl/atm_keypad_entry_pkg.sv
// atm_keypad_entry_pkg: shared key codes, op codes, FSM states, error codes and field limits
package atm_keypad_entry_pkg;
   typedef enum logic [2:0] {S_ACC, S_PIN, S_OP, S_AMT, S_NPIN, S_SEND} state_t;
   localparam logic [3:0] K_ENTER = 4'd10;
   localparam logic [3:0] K_CLEAR = 4'd11;
   localparam logic [3:0] K_CANCEL = 4'd12;
   localparam logic [3:0] K_LANG = 4'd13;
   localparam logic [2:0] OP_BAL = 3'd3;
   localparam logic [2:0] OP_WD = 3'd4;
   localparam logic [2:0] OP_DEP = 3'd5;
   localparam logic [2:0] OP_CHPIN = 3'd6;
   localparam logic [1:0] E_DIGITS = 2'd1;
   localparam logic [1:0] E_ENTER = 2'd2;
   localparam logic [1:0] E_TIMEOUT = 2'd3;
   function automatic logic [3:0] field_max(state_t s, logic [3:0] amt);
      return s == S_ACC ? 4'd2 : (s == S_PIN || s == S_NPIN) ? 4'd4 : s == S_OP ? 4'd1 :
             s == S_AMT ? amt : 4'd0;
   endfunction
endpackage

// File: rtl/atm_keypad_entry_dec_accum.sv
// atm_keypad_entry_dec_accum: decimal-to-binary accumulator with digit counter and limit check
module atm_keypad_entry_dec_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        digit_en,
   input  logic [3:0]  digit,
   input  logic [3:0]  max_digits,
   output logic [31:0] value,
   output logic [3:0]  count,
   output logic        overflow
);
   assign overflow = digit_en && count >= max_digits;
   // shift in one decimal digit per accepted key; a digit over the limit is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
         count <= '0;
      end else if (clr) begin
         value <= '0;
         count <= '0;
      end else if (digit_en && !overflow) begin
         value <= (value << 3) + (value << 1) + {28'd0, digit};
         count <= count + 4'd1;
      end
   end
endmodule

// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front-end assembling an ATM transaction with valid/ready hand-off
module atm_keypad_entry
   import atm_keypad_entry_pkg::*;
#(
   parameter int AMT_DIGITS = 6,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int NUM_ACCOUNTS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        txn_ready,
   output logic        txn_valid,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic [2:0]  operation,
   output logic [31:0] amount,
   output logic [15:0] new_pin,
   output logic        language,
   output logic [2:0]  entry_st,
   output logic [3:0]  digit_cnt,
   output logic        err,
   output logic [1:0]  err_code
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t st;
   logic [TW-1:0] timer;
   logic [31:0] value;
   logic overflow, key_ok, is_digit, is_enter, is_clear, is_cancel, is_lang;
   logic enter_ok, tmr_on, timeout, acc_clr;
   assign entry_st = st;
   // key decode, field validation and timeout detection; keys are dead while a transaction waits
   always_comb begin
      key_ok = key_valid && st != S_SEND;
      is_digit = key_ok && key_code <= 4'd9;
      is_enter = key_ok && key_code == K_ENTER;
      is_clear = key_ok && key_code == K_CLEAR;
      is_cancel = key_ok && key_code == K_CANCEL;
      is_lang = key_ok && key_code == K_LANG;
      tmr_on = st != S_SEND && (st != S_ACC || digit_cnt != 4'd0);
      timeout = tmr_on && !key_valid && timer == TW'(TIMEOUT_CYCLES - 1);
      enter_ok = st == S_ACC ? (value >= 32'd1 && value <= 32'(NUM_ACCOUNTS)) :
                 (st == S_PIN || st == S_NPIN) ? digit_cnt == 4'd4 :
                 st == S_OP ? (digit_cnt == 4'd1 && value <= 32'd7) :
                 st == S_AMT ? digit_cnt != 4'd0 : 1'b0;
      acc_clr = is_enter || is_clear || is_cancel || timeout;
   end
   atm_keypad_entry_dec_accum u_accum (
      .clk(clk),
      .rst(rst),
      .clr(acc_clr),
      .digit_en(is_digit),
      .digit(key_code),
      .max_digits(field_max(st, 4'(AMT_DIGITS))),
      .value(value),
      .count(digit_cnt),
      .overflow(overflow)
   );
   // inactivity timer: any key restarts it; idle while nothing is pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer <= '0;
      else timer <= (key_valid || !tmr_on || timeout) ? '0 : timer + 1'b1;
   end
   // entry FSM with registered transaction fields, language and error pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st <= S_ACC;
         txn_valid <= 1'b0;
         acc_num <= '0;
         pin <= '0;
         operation <= '0;
         amount <= '0;
         new_pin <= '0;
         language <= 1'b0;
         err <= 1'b0;
         err_code <= '0;
      end else begin
         err <= 1'b0;
         err_code <= '0;
         if ((st == S_SEND && txn_ready) || is_cancel || timeout) begin
            st <= S_ACC;
            txn_valid <= 1'b0;
            acc_num <= '0;
            pin <= '0;
            operation <= '0;
            amount <= '0;
            new_pin <= '0;
            err <= timeout;
            err_code <= timeout ? E_TIMEOUT : 2'd0;
         end else if (is_lang) begin
            language <= ~language;
         end else if (is_digit && overflow) begin
            err <= 1'b1;
            err_code <= E_DIGITS;
         end else if (is_enter && !enter_ok) begin
            err <= 1'b1;
            err_code <= E_ENTER;
         end else if (is_enter) begin
            case (st)
               S_ACC: begin
                  acc_num <= value[3:0];
                  st <= S_PIN;
               end
               S_PIN: begin
                  pin <= value[15:0];
                  st <= S_OP;
               end
               S_OP: begin
                  operation <= value[2:0];
                  st <= (value[2:0] == OP_WD || value[2:0] == OP_DEP) ? S_AMT :
                        value[2:0] == OP_CHPIN ? S_NPIN : S_SEND;
                  txn_valid <= value[2:0] != OP_WD && value[2:0] != OP_DEP && value[2:0] != OP_CHPIN;
               end
               S_AMT: begin
                  amount <= value;
                  st <= S_SEND;
                  txn_valid <= 1'b1;
               end
               S_NPIN: begin
                  new_pin <= value[15:0];
                  st <= S_SEND;
                  txn_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
